// File: rtl/data_mem_pkg.sv
// Shared definitions for the banked data memory: default widths, clear-FSM
// state encoding and the byte-lane merge used by the store path.
package data_mem_pkg;

  localparam int DEF_ADDR_BITS = 10;
  localparam int DEF_DATA_BITS = 32;

  // Widest word byte_merge can handle; callers zero-extend and truncate.
  localparam int MAX_DATA_BITS = 128;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  function automatic logic [MAX_DATA_BITS-1:0] byte_merge(
    input logic [MAX_DATA_BITS-1:0]   old_word,
    input logic [MAX_DATA_BITS-1:0]   new_word,
    input logic [MAX_DATA_BITS/8-1:0] lanes
  );
    logic [MAX_DATA_BITS-1:0] merged;
    merged = old_word;
    for (int k = 0; k < MAX_DATA_BITS / 8; k++) begin
      if (lanes[k]) merged[8*k +: 8] = new_word[8*k +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/mem_clear_seq.sv
// Bulk-clear sequencer: walks every word of the array writing zero, one per
// cycle, and reports busy while doing so. Reset always starts a clear.
module mem_clear_seq
  import data_mem_pkg::*;
#(
  parameter int IDX_BITS = 10,
  parameter int DEPTH    = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  output logic                busy,
  output logic                clr_we,
  output logic [IDX_BITS-1:0] clr_addr
);

  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(DEPTH - 1);

  clr_state_t          state;
  logic [IDX_BITS-1:0] clr_idx;

  // A clear request seen while already clearing is ignored, so the clear
  // always lasts exactly DEPTH cycles from the edge that started it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
      busy    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (clr) begin
            state   <= CLEAR;
            clr_idx <= '0;
            busy    <= 1'b1;
          end
        end
        CLEAR: begin
          if (clr_idx == LAST_IDX) begin
            state   <= IDLE;
            clr_idx <= '0;
            busy    <= 1'b0;
          end else begin
            clr_idx <= clr_idx + IDX_BITS'(1);
          end
        end
        default: begin
          state   <= CLEAR;
          clr_idx <= '0;
          busy    <= 1'b1;
        end
      endcase
    end
  end

  assign clr_we   = (state == CLEAR);
  assign clr_addr = clr_idx;

endmodule

// File: rtl/banked_data_mem.sv
// Byte-writable single-port data memory with registered read data, range
// checking and a sequential bulk clear that owns the array while busy.
module banked_data_mem
  import data_mem_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int DEPTH     = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   sel,
  input  logic                   str,
  input  logic                   ld,
  input  logic [DATA_BITS/8-1:0] be,
  input  logic [ADDR_BITS-1:0]   addr,
  input  logic [DATA_BITS-1:0]   data_in,
  output logic [DATA_BITS-1:0]   data_out,
  output logic                   rd_valid,
  output logic                   addr_err,
  output logic                   busy
);

  localparam int NBYTES   = DATA_BITS / 8;
  localparam int IDX_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_BITS:0] DEPTH_W = (ADDR_BITS + 1)'(DEPTH);

  logic [DATA_BITS-1:0] mem [DEPTH];

  logic                 clr_we;
  logic [IDX_BITS-1:0]  clr_addr;
  logic [IDX_BITS-1:0]  idx;
  logic                 in_range;
  logic                 accept;
  logic                 acc_we;
  logic [DATA_BITS-1:0] rd_word;
  logic [DATA_BITS-1:0] merged;

  mem_clear_seq #(
    .IDX_BITS (IDX_BITS),
    .DEPTH    (DEPTH)
  ) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // idx may point past the array when out of range; every use is gated by in_range.
  assign idx      = addr[IDX_BITS-1:0];
  assign in_range = ({1'b0, addr} < DEPTH_W);
  assign accept   = !rst && !busy && !clr && sel;
  assign acc_we   = accept && str && in_range;
  assign rd_word  = mem[idx];
  assign merged   = DATA_BITS'(byte_merge(MAX_DATA_BITS'(rd_word),
                                          MAX_DATA_BITS'(data_in),
                                          (MAX_DATA_BITS / 8)'(be)));

  // Single write port shared between the clear sequencer and the store path.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (acc_we) begin
      mem[idx] <= merged;
    end
  end

  // A store-and-load returns the merged word so the load sees its own store.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
      if (accept && (str || ld)) begin
        if (!in_range) begin
          addr_err <= 1'b1;
          if (ld) begin
            data_out <= '0;
            rd_valid <= 1'b1;
          end
        end else if (ld) begin
          data_out <= str ? merged : rd_word;
          rd_valid <= 1'b1;
        end
      end
    end
  end

  logic unused_nbytes;
  assign unused_nbytes = (NBYTES == 0);

endmodule

// File: tb/tb_banked_data_mem.sv
// Directed bench for banked_data_mem (16 x 32, 5-bit address) with a
// scoreboard of expected outputs pushed per step and popped after each edge.
module tb_banked_data_mem;
  import data_mem_pkg::*;

  localparam int AB = 5;
  localparam int DB = 32;
  localparam int DP = 16;

  logic          clk = 1'b0;
  logic          rst, clr, sel, str, ld;
  logic [3:0]    be;
  logic [AB-1:0] addr;
  logic [DB-1:0] data_in;
  logic [DB-1:0] data_out;
  logic          rd_valid, addr_err, busy;

  always #5 clk = ~clk;

  banked_data_mem #(
    .ADDR_BITS (AB),
    .DATA_BITS (DB),
    .DEPTH     (DP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .sel      (sel),
    .str      (str),
    .ld       (ld),
    .be       (be),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .rd_valid (rd_valid),
    .addr_err (addr_err),
    .busy     (busy)
  );

  typedef struct {
    string         tag;
    logic [DB-1:0] data;
    logic          rv;
    logic          ae;
    logic          bz;
  } exp_t;

  exp_t          sb[$];
  logic [DB-1:0] model [DP];
  logic [DB-1:0] m_data;
  int            left;
  int            checks;
  int            errors;

  // Drive one cycle of inputs, advance the reference model, queue the result.
  task automatic applyStimulus(input string tag, input logic r, input logic c,
                               input logic s, input logic st, input logic l,
                               input logic [3:0] b, input logic [AB-1:0] a,
                               input logic [DB-1:0] d);
    exp_t e;
    int   ai;
    rst = r; clr = c; sel = s; str = st; ld = l; be = b; addr = a; data_in = d;
    e.rv = 1'b0;
    e.ae = 1'b0;
    ai   = int'(a);
    if (r) begin
      left   = DP;
      m_data = '0;
      for (int i = 0; i < DP; i++) model[i] = '0;
    end else if (left > 0) begin
      left--;
    end else if (c) begin
      left = DP;
      for (int i = 0; i < DP; i++) model[i] = '0;
    end else if (s && (st || l)) begin
      if (ai >= DP) begin
        e.ae = 1'b1;
        if (l) begin
          e.rv   = 1'b1;
          m_data = '0;
        end
      end else begin
        if (st) model[ai] = DB'(byte_merge(MAX_DATA_BITS'(model[ai]),
                                           MAX_DATA_BITS'(d),
                                           (MAX_DATA_BITS / 8)'(b)));
        if (l) begin
          e.rv   = 1'b1;
          m_data = model[ai];
        end
      end
    end
    e.tag  = tag;
    e.data = m_data;
    e.bz   = (left > 0);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput();
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard_empty observed 0 entries expected 1");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks += 4;
      assert (data_out === e.data) else begin
        errors++;
        $error("[TB] FAIL %s data_out observed %h expected %h", e.tag, data_out, e.data);
      end
      assert (rd_valid === e.rv) else begin
        errors++;
        $error("[TB] FAIL %s rd_valid observed %b expected %b", e.tag, rd_valid, e.rv);
      end
      assert (addr_err === e.ae) else begin
        errors++;
        $error("[TB] FAIL %s addr_err observed %b expected %b", e.tag, addr_err, e.ae);
      end
      assert (busy === e.bz) else begin
        errors++;
        $error("[TB] FAIL %s busy observed %b expected %b", e.tag, busy, e.bz);
      end
    end
  endtask

  task automatic step(input string tag, input logic r, input logic c,
                      input logic s, input logic st, input logic l,
                      input logic [3:0] b, input logic [AB-1:0] a,
                      input logic [DB-1:0] d);
    applyStimulus(tag, r, c, s, st, l, b, a, d);
    checkOutput();
  endtask

  task automatic checkValue(input string tag, input logic [DB-1:0] obs,
                            input logic [DB-1:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, obs, req);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    left   = 0;
    m_data = '0;
    rst = 1'b0; clr = 1'b0; sel = 1'b0; str = 1'b0; ld = 1'b0;
    be = '0; addr = '0; data_in = '0;

    step("reset", 1, 0, 0, 0, 0, 4'h0, 5'd0, 32'h0);
    for (int i = 0; i < DP + 1; i++) step("reset_clear", 0, 0, 0, 0, 0, 4'h0, 5'd0, 32'h0);
    for (int i = 0; i < DP; i++) step("load_zero", 0, 0, 1, 0, 1, 4'h0, AB'(i), 32'h0);

    step("store_full", 0, 0, 1, 1, 0, 4'hF, 5'd5, 32'hAABBCCDD);
    step("store_0101", 0, 0, 1, 1, 0, 4'h5, 5'd5, 32'h11223344);
    step("load_5", 0, 0, 1, 0, 1, 4'h0, 5'd5, 32'h0);
    checkValue("byte_store_value", data_out, 32'hAA22CC44);

    step("wt_store_load", 0, 0, 1, 1, 1, 4'h8, 5'd7, 32'hFF000000);
    checkValue("write_through_value", data_out, 32'hFF000000);
    step("wt_reload", 0, 0, 1, 0, 1, 4'h0, 5'd7, 32'h0);
    step("be_zero_store_load", 0, 0, 1, 1, 1, 4'h0, 5'd7, 32'h12121212);

    step("oor_store", 0, 0, 1, 1, 0, 4'hF, 5'd20, 32'h12345678);
    step("oor_load", 0, 0, 1, 0, 1, 4'h0, 5'd20, 32'h0);
    checkValue("oor_load_value", data_out, 32'h0);
    step("oor_edge_load", 0, 0, 1, 1, 1, 4'hF, 5'd16, 32'h55555555);
    for (int i = 0; i < DP; i++) step("oor_unchanged", 0, 0, 1, 0, 1, 4'h0, AB'(i), 32'h0);

    step("prime_load_5", 0, 0, 1, 0, 1, 4'h0, 5'd5, 32'h0);
    step("sel_gated", 0, 0, 0, 1, 1, 4'hF, 5'd5, 32'h0BADF00D);
    step("sel_recheck", 0, 0, 1, 0, 1, 4'h0, 5'd5, 32'h0);
    checkValue("sel_gated_value", data_out, 32'hAA22CC44);

    step("clr_with_access", 0, 1, 1, 1, 1, 4'hF, 5'd3, 32'hDEADBEEF);
    for (int i = 0; i < DP; i++) begin
      if (i == 5) step("clr_reassert", 0, 1, 0, 0, 0, 4'h0, 5'd0, 32'h0);
      else        step("clr_run", 0, 0, 1, 1, 1, 4'hF, 5'd3, 32'hDEADBEEF);
    end
    step("clr_load_3", 0, 0, 1, 0, 1, 4'h0, 5'd3, 32'h0);

    step("pre_rst_store", 0, 0, 1, 1, 0, 4'hF, 5'd2, 32'hCAFEF00D);
    step("pre_rst_load", 0, 0, 1, 0, 1, 4'h0, 5'd2, 32'h0);
    step("clr_again", 0, 1, 0, 0, 0, 4'h0, 5'd0, 32'h0);
    for (int i = 0; i < 5; i++) step("clr_partial", 0, 0, 0, 0, 0, 4'h0, 5'd0, 32'h0);
    step("rst_mid_clear", 1, 0, 0, 0, 0, 4'h0, 5'd0, 32'h0);
    for (int i = 0; i < DP; i++) step("rst_reclear", 0, 0, 0, 0, 0, 4'h0, 5'd0, 32'h0);
    step("post_rst_load_2", 0, 0, 1, 0, 1, 4'h0, 5'd2, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/banked_data_mem.md
Name: banked_data_mem

Overview:
- Parametrised, byte-writable, single-port synchronous data memory for the CPU data path.
- Successor to the fixed 1024x32 store.
- Adds the following over that store:
  - configurable width and depth;
  - per-byte write strobes;
  - a registered read-valid flag;
  - out-of-range detection;
  - a synthesizable sequential bulk clear (one word per cycle) with a busy indication.
- Sits between the MEM pipeline stage and the load/store unit.

Parameters:
ADDR_BITS, 10, address width in bits.
DATA_BITS, 32, word width in bits; must be a multiple of 8.
DEPTH, 1024, number of words implemented; must satisfy DEPTH <= 2**ADDR_BITS.
NBYTES, DATA_BITS/8, derived localparam; number of byte lanes.

Ports:
clk  in  1  clock; all logic is on the rising edge.
rst  in  1  synchronous, active-high reset.
clr  in  1  bulk-clear request; sampled only in IDLE.
sel  in  1  access select; when 0, addr, data_in, str, ld and be are ignored.
str  in  1  store enable.
ld  in  1  load enable.
be  in  NBYTES  byte-lane write strobes; bit k covers data bits [8k+7:8k].
addr  in  ADDR_BITS  word address.
data_in  in  DATA_BITS  write data.
data_out  out  DATA_BITS  read data, registered.
rd_valid  out  1  one-cycle pulse; data_out is new this cycle.
addr_err  out  1  one-cycle pulse; an accepted access had addr >= DEPTH.
busy  out  1  high while a clear is in progress; accesses are ignored while high.

Behaviour:
- Reset values (rst=1 at an edge): data_out=0, rd_valid=0, addr_err=0, busy=1. The FSM enters CLEAR with clr_idx=0. rst therefore always zeroes the memory.
- rst mid-clear restarts the clear at clr_idx=0.
- FSM states: IDLE, CLEAR.
  - CLEAR: each cycle writes mem[clr_idx]=0 and increments clr_idx.
  - CLEAR -> IDLE at the edge that writes clr_idx=DEPTH-1. The clear lasts exactly DEPTH cycles; busy drops the cycle after.
  - clr=1 in CLEAR is ignored and does not restart the clear.
  - IDLE: clr=1 -> CLEAR with clr_idx=0. clr has priority over a simultaneous access, which is dropped.
- Access in IDLE with clr=0 and sel=1, decoded on {str,ld}:
  - 00: no operation. data_out holds its value; rd_valid=0.
  - 01 (load): data_out <= mem[addr] at the next edge; rd_valid=1 in that cycle. Latency is 1.
  - 10 (store): for each k with be[k]=1, mem[addr] lane k <= data_in lane k. data_out holds; rd_valid=0.
  - 11 (store and load, write-through): the byte-merged word is written. data_out <= merged word, i.e. new lanes where be=1 and old lanes otherwise; rd_valid=1.
- sel=0: no operation, outputs hold, rd_valid=0. data_out is never tri-stated.
- be=0 with str=1: no memory change. A load in the same access still proceeds.
- Out of range (addr >= DEPTH) on an accepted access with str or ld set:
  - writes are dropped;
  - a load returns 0 with rd_valid=1;
  - addr_err=1 for one cycle.
- Read-after-write: a load on the cycle after a store to the same address returns the stored data (the array is updated at the store edge).
- Initial contents are don't-care for simulation; reset defines them.

Decomposition:
- Shared package data_mem_pkg holds:
  - localparams for the default ADDR_BITS/DATA_BITS;
  - the FSM state encoding (IDLE=1'b0, CLEAR=1'b1);
  - a function byte_merge(old, new, be) used by both RTL and testbench.
- One natural sub-module: mem_clear_seq. It holds the clr_idx counter, the state register, busy, and the clear write-enable and address. The top muxes the array port between the clear sequencer and the access path.

Test Plan:
- Reset clear: DEPTH=16. Pulse rst, then hold all inputs low. busy=1 for exactly 16 cycles. Loads of addr 0..15 then return 0 with rd_valid one cycle after each request.
- Byte store: DATA_BITS=32. Store 0xAABBCCDD to addr 5 with be=4'b1111, then store 0x11223344 with be=4'b0101. A load of addr 5 returns 0xAA22CC44, rd_valid one cycle later.
- Write-through: mem[7]=0x00000000. Apply sel=1, str=1, ld=1, be=4'b1000, data_in=0xFF000000 at addr 7. The next cycle gives data_out=0xFF000000 and rd_valid=1. A subsequent load of addr 7 returns 0xFF000000.
- Out of range: DEPTH=16, ADDR_BITS=5. Store 0x12345678 to addr 20, then load addr 20. The response is addr_err=1 on both, the load returns data_out=0, and the contents of addr 0..15 are unchanged.
- Clear contention:
  - Issue clr together with a store; the store is dropped.
  - Re-assert clr mid-clear; busy still lasts exactly DEPTH cycles.
  - Assert rst mid-clear; busy lasts DEPTH cycles counted from rst.
- sel gating: with sel=0 and str=ld=1, data_out holds its previous value, rd_valid=0, and memory is unchanged.
